// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character-LCD bus: read-engine state
// encoding, bus protocol constants and a small elaboration helper.
package lcd_pkg;

    typedef enum logic [2:0] {
        RD_IDLE  = 3'd0,
        RD_SETUP = 3'd1,
        RD_EN_HI = 3'd2,
        RD_EN_LO = 3'd3,
        RD_DONE  = 3'd4
    } lcd_rd_state_t;

    localparam int         LCD_BF_BIT    = 7;
    localparam logic [6:0] LCD_ADDR_MASK = 7'h7F;
    localparam logic       LCD_RW_READ   = 1'b1;
    localparam logic       LCD_RW_WRITE  = 1'b0;

    function automatic int lcd_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_bus_reader_if.sv
// Request/response handshake plus LCD pad-side signals of the read engine.
// The slave modport is the reader; the master modport is whoever drives it.
interface lcd_bus_reader_if;

    logic       iStart;
    logic       iRS;
    logic       iPoll;
    logic       oReady;
    logic       oDone;
    logic [7:0] oData;
    logic       oTimeout;
    logic       oBusOwn;
    logic [7:0] LCD_DATA_IN;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;

    modport slave (
        input  iStart, iRS, iPoll, LCD_DATA_IN,
        output oReady, oDone, oData, oTimeout, oBusOwn,
        output LCD_RS, LCD_RW, LCD_EN
    );

    modport master (
        output iStart, iRS, iPoll, LCD_DATA_IN,
        input  oReady, oDone, oData, oTimeout, oBusOwn,
        input  LCD_RS, LCD_RW, LCD_EN
    );

endinterface

// File: rtl/lcd_bus_reader.sv
// HD44780 read engine: one busy-flag/address or data read per request, or
// busy-flag polling until BF clears or the poll limit is reached.
module lcd_bus_reader #(
    parameter int SETUP_CYC   = 2,
    parameter int EN_HIGH_CYC = 25,
    parameter int EN_LOW_CYC  = 25,
    parameter int POLL_MAX    = 4095
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    lcd_bus_reader_if.slave   bus
);

    import lcd_pkg::*;

    localparam int CNT_W = $clog2(lcd_max3(SETUP_CYC, EN_HIGH_CYC, EN_LOW_CYC) + 1);
    localparam int PC_W  = $clog2(POLL_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_HI_LOAD = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LO_LOAD = CNT_W'(EN_LOW_CYC - 1);
    localparam logic [PC_W-1:0]  POLL_LIM   = PC_W'(POLL_MAX);

    lcd_rd_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  poll_cnt_q, poll_cnt_d;
    logic             rs_q, rs_d;
    logic             poll_q, poll_d;
    logic [7:0]       data_q, data_d;
    logic             timeout_q, timeout_d;

    logic phase_end;
    logic accept;
    logic sample;
    logic poll_again;

    assign phase_end  = (cnt_q == '0);
    assign accept     = (state_q == RD_IDLE) && bus.iStart;
    assign sample     = (state_q == RD_EN_HI) && phase_end;
    assign poll_again = poll_q && data_q[LCD_BF_BIT] && (poll_cnt_q < POLL_LIM);

    // State register and datapath flops; everything returns to idle values
    // asynchronously so EN drops the moment reset is asserted.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= RD_IDLE;
            cnt_q      <= '0;
            poll_cnt_q <= '0;
            rs_q       <= 1'b0;
            poll_q     <= 1'b0;
            data_q     <= 8'h00;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            poll_cnt_q <= poll_cnt_d;
            rs_q       <= rs_d;
            poll_q     <= poll_d;
            data_q     <= data_d;
            timeout_q  <= timeout_d;
        end
    end

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RD_IDLE:  if (bus.iStart) state_d = RD_SETUP;
            RD_SETUP: if (phase_end)  state_d = RD_EN_HI;
            RD_EN_HI: if (phase_end)  state_d = RD_EN_LO;
            RD_EN_LO: if (phase_end)  state_d = poll_again ? RD_SETUP : RD_DONE;
            RD_DONE:                  state_d = RD_IDLE;
            default:                  state_d = RD_IDLE;
        endcase
    end

    // One shared phase counter, reloaded whenever a timed state is entered.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            unique case (state_d)
                RD_SETUP: cnt_d = SETUP_LOAD;
                RD_EN_HI: cnt_d = EN_HI_LOAD;
                RD_EN_LO: cnt_d = EN_LO_LOAD;
                default:  cnt_d = '0;
            endcase
        end else if (!phase_end) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Request latching, bus sampling, poll counting and completion status.
    always_comb begin
        rs_d       = rs_q;
        poll_d     = poll_q;
        poll_cnt_d = poll_cnt_q;
        data_d     = data_q;
        timeout_d  = timeout_q;

        if (accept) begin
            rs_d       = bus.iRS;
            poll_d     = bus.iPoll && !bus.iRS;
            poll_cnt_d = '0;
        end

        if (sample) begin
            data_d = bus.LCD_DATA_IN;
            if (poll_cnt_q != POLL_LIM) begin
                poll_cnt_d = poll_cnt_q + 1'b1;
            end
        end

        if ((state_d == RD_DONE) && (state_q != RD_DONE)) begin
            timeout_d = poll_q && data_q[LCD_BF_BIT];
        end
    end

    // Output decode straight from the state register; RS/RW stay put from
    // SETUP entry until DONE exit.
    always_comb begin
        bus.oReady  = 1'b0;
        bus.oDone   = 1'b0;
        bus.oBusOwn = 1'b1;
        bus.LCD_RW  = LCD_RW_READ;
        bus.LCD_RS  = rs_q;
        bus.LCD_EN  = 1'b0;
        unique case (state_q)
            RD_IDLE: begin
                bus.oReady  = 1'b1;
                bus.oBusOwn = 1'b0;
                bus.LCD_RW  = LCD_RW_WRITE;
                bus.LCD_RS  = 1'b0;
            end
            RD_EN_HI: bus.LCD_EN = 1'b1;
            RD_DONE:  bus.oDone  = 1'b1;
            default: ;
        endcase
    end

    assign bus.oData    = data_q;
    assign bus.oTimeout = timeout_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader: a pad model answers reads while RW=1,
// and a scoreboard queue holds the expected outcome of every request.
module tb_lcd_bus_reader;

    import lcd_pkg::*;

    localparam int SETUP   = 2;
    localparam int EN_HIGH = 25;
    localparam int EN_LOW  = 25;
    localparam int PMAX    = 4;
    localparam int P       = SETUP + EN_HIGH + EN_LOW;

    typedef struct {
        logic [7:0] data;
        logic       tmo;
        int         pulses;
        int         lat;
    } exp_t;

    logic iCLK = 1'b0;
    logic iRST_N;

    lcd_bus_reader_if bus ();

    lcd_bus_reader #(
        .SETUP_CYC   (SETUP),
        .EN_HIGH_CYC (EN_HIGH),
        .EN_LOW_CYC  (EN_LOW),
        .POLL_MAX    (PMAX)
    ) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (bus.slave)
    );

    always #10 iCLK = ~iCLK;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    // Pad model: first switch_n pulses of a request see pad_a, later ones pad_b.
    logic [7:0] pad_a = 8'h00;
    logic [7:0] pad_b = 8'h00;
    int         switch_n = 1000;
    int         en_pulses = 0;
    assign bus.LCD_DATA_IN = (bus.LCD_RW === LCD_RW_READ)
                           ? ((en_pulses <= switch_n) ? pad_a : pad_b) : 8'h00;

    always @(posedge bus.LCD_EN) en_pulses++;

    int   cyc = 0;
    int   e0_cyc = 0;
    always @(posedge iCLK) cyc++;

    // Protocol monitor on the falling clock edge.
    logic cur_rs = 1'b0;
    int   ctl_viol = 0;
    int   en_run = 0;
    int   w_min = 9999;
    int   w_max = 0;
    int   done_seen = 0;
    always @(negedge iCLK) begin
        if (bus.oBusOwn === 1'b1 && (bus.LCD_RW !== 1'b1 || bus.LCD_RS !== cur_rs))
            ctl_viol++;
        if (bus.LCD_EN === 1'b1) begin
            en_run++;
        end else if (en_run != 0) begin
            if (en_run < w_min) w_min = en_run;
            if (en_run > w_max) w_max = en_run;
            en_run = 0;
        end
        if (bus.oDone === 1'b1) done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_txn(input string tag, input logic rs, input logic poll, input exp_t e);
        exp_q.push_back(e);
        cur_rs    = rs;
        en_pulses = 0;
        w_min     = 9999;
        w_max     = 0;
        ctl_viol  = 0;
        @(negedge iCLK);
        bus.iRS    = rs;
        bus.iPoll  = poll;
        bus.iStart = 1'b1;
        @(posedge iCLK);
        #1;
        e0_cyc     = cyc;
        bus.iStart = 1'b0;
        check({tag, " accepted"}, bus.oReady, 1'b0);
    endtask

    task automatic wait_done(input string tag);
        bit   got;
        exp_t e;
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.oDone === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge iCLK);
            #1;
        end
        e = exp_q.pop_front();
        check({tag, " done_seen"}, got, 1'b1);
        if (got) begin
            check({tag, " latency"}, cyc - e0_cyc, e.lat);
            check({tag, " data"}, bus.oData, e.data);
            check({tag, " timeout"}, bus.oTimeout, e.tmo);
            check({tag, " pulses"}, en_pulses, e.pulses);
            check({tag, " en_width_min"}, w_min, EN_HIGH);
            check({tag, " en_width_max"}, w_max, EN_HIGH);
            check({tag, " rs_rw_stable"}, ctl_viol, 0);
            @(posedge iCLK);
            #1;
            check({tag, " ready_after"}, {bus.oReady, bus.oDone}, 2'b10);
            check({tag, " data_held"}, bus.oData, e.data);
        end
    endtask

    task automatic wait_en(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge iCLK);
            if (bus.LCD_EN === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int  dev;
        int  done_before;
        bit  seen;

        bus.iStart = 1'b0;
        bus.iRS    = 1'b0;
        bus.iPoll  = 1'b0;
        iRST_N     = 1'b0;
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;

        // Idle after reset: nothing moves for 100 cycles.
        dev = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge iCLK);
            if ({bus.oReady, bus.oDone, bus.oData, bus.oTimeout, bus.oBusOwn,
                 bus.LCD_RS, bus.LCD_RW, bus.LCD_EN} !== {1'b1, 1'b0, 8'h00, 5'b00000})
                dev++;
        end
        check("idle stable", dev, 0);
        check("rst oReady", bus.oReady, 1'b1);
        check("rst oDone", bus.oDone, 1'b0);
        check("rst oData", bus.oData, 8'h00);
        check("rst oTimeout", bus.oTimeout, 1'b0);
        check("rst oBusOwn", bus.oBusOwn, 1'b0);
        check("rst LCD_RS", bus.LCD_RS, 1'b0);
        check("rst LCD_RW", bus.LCD_RW, 1'b0);
        check("rst LCD_EN", bus.LCD_EN, 1'b0);

        // Data read.
        pad_a = 8'h41; switch_n = 1000;
        start_txn("rd_data", 1'b1, 1'b0, '{8'h41, 1'b0, 1, P});
        wait_done("rd_data");

        // Data read with iPoll set and bit7 high: poll request is ignored.
        pad_a = 8'hC1;
        start_txn("rd_data_poll", 1'b1, 1'b1, '{8'hC1, 1'b0, 1, P});
        wait_done("rd_data_poll");

        // Single BF read with BF=1 and no polling.
        pad_a = 8'hA5;
        start_txn("bf_single", 1'b0, 1'b0, '{8'hA5, 1'b0, 1, P});
        wait_done("bf_single");

        // Poll: busy for two reads, then clear.
        pad_a = 8'h85; pad_b = 8'h05; switch_n = 2;
        start_txn("bf_poll", 1'b0, 1'b1, '{8'h05, 1'b0, 3, 3 * P});
        wait_done("bf_poll");

        // Poll timeout: busy flag stuck high.
        pad_a = 8'h80; switch_n = 1000;
        start_txn("bf_timeout", 1'b0, 1'b1, '{8'h80, 1'b1, PMAX, PMAX * P});
        wait_done("bf_timeout");

        // iStart while busy is ignored.
        pad_a = 8'h3C;
        start_txn("busy_start", 1'b1, 1'b0, '{8'h3C, 1'b0, 1, P});
        wait_en(seen);
        check("busy_start en_seen", seen, 1'b1);
        bus.iRS    = 1'b0;
        bus.iPoll  = 1'b1;
        bus.iStart = 1'b1;
        @(negedge iCLK);
        bus.iStart = 1'b0;
        wait_done("busy_start");
        dev = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge iCLK);
            if (bus.oReady !== 1'b1 || bus.LCD_EN !== 1'b0) dev++;
        end
        check("busy_start no_requeue", dev, 0);

        // Reset mid-EN_HI aborts the read with no completion pulse.
        pad_a = 8'h77;
        cur_rs = 1'b1;
        en_pulses = 0;
        @(negedge iCLK);
        bus.iRS    = 1'b1;
        bus.iPoll  = 1'b0;
        bus.iStart = 1'b1;
        @(negedge iCLK);
        bus.iStart = 1'b0;
        wait_en(seen);
        check("abort en_seen", seen, 1'b1);
        repeat (10) @(negedge iCLK);
        done_before = done_seen;
        #3;
        iRST_N = 1'b0;
        #1;
        check("abort LCD_EN", bus.LCD_EN, 1'b0);
        check("abort oBusOwn", bus.oBusOwn, 1'b0);
        check("abort LCD_RW", bus.LCD_RW, 1'b0);
        check("abort oReady", bus.oReady, 1'b1);
        check("abort oData", bus.oData, 8'h00);
        repeat (5) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (80) @(negedge iCLK);
        check("abort no_done", done_seen - done_before, 0);
        check("abort ready", bus.oReady, 1'b1);

        // Normal read after recovery.
        pad_a = 8'h5A;
        start_txn("after_rst", 1'b1, 1'b0, '{8'h5A, 1'b0, 1, P});
        wait_done("after_rst");

        check("scoreboard empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
